// File: rtl/konark_tohost_arbiter_if.sv
// Core request bus plus tohost mailbox bus for the Konark tohost arbiter.
interface konark_tohost_arbiter_if #(
  parameter int unsigned NrCores   = 4,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned CoreW = (NrCores > 1) ? $clog2(NrCores) : 1;

  logic [NrCores-1:0]           core_req_valid_i;
  logic [NrCores*DataWidth-1:0] core_req_data_i;
  logic [NrCores-1:0]           core_req_ready_o;
  logic                         tohost_valid_o;
  logic [DataWidth-1:0]         tohost_data_o;
  logic [CoreW-1:0]             tohost_core_o;
  logic                         tohost_ack_i;

  // Cores and host side
  modport master (
    output core_req_valid_i, core_req_data_i, tohost_ack_i,
    input  core_req_ready_o, tohost_valid_o, tohost_data_o, tohost_core_o
  );

  // Arbiter side
  modport slave (
    input  core_req_valid_i, core_req_data_i, tohost_ack_i,
    output core_req_ready_o, tohost_valid_o, tohost_data_o, tohost_core_o
  );
endinterface

// File: rtl/konark_tohost_arbiter.sv
// Round-robin arbiter for the shared tohost mailbox with exit detection and drain window.
module konark_tohost_arbiter #(
  parameter int unsigned NrCores     = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned DrainCycles = 200
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  konark_tohost_arbiter_if.slave   bus,
  output logic                     exit_o,
  output logic [DataWidth-2:0]     exit_code_o,
  output logic                     busy_o
);
  localparam int unsigned CoreW = (NrCores > 1) ? $clog2(NrCores) : 1;
  localparam int unsigned CntW  = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] POST   = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] EXITED = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CoreW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [CoreW-1:0]     core_q, core_d;
  logic [DataWidth-2:0] code_q, code_d;
  logic                 exit_q, exit_d;

  logic                 gnt_found;
  logic [CoreW-1:0]     gnt_idx;
  logic [CoreW-1:0]     cand;

  // First requester at or after rr_ptr, wrapping modulo NrCores
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      cand = CoreW'((32'(rr_ptr_q) + i) % NrCores);
      if (!gnt_found && bus.core_req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state logic and the combinational per-core accept
  always_comb begin
    state_d              = state_q;
    rr_ptr_d             = rr_ptr_q;
    cnt_d                = cnt_q;
    data_d               = data_q;
    core_d               = core_q;
    code_d               = code_q;
    exit_d               = exit_q | (state_q == EXITED);
    bus.core_req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          bus.core_req_ready_o[gnt_idx] = 1'b1;
          data_d  = bus.core_req_data_i[32'(gnt_idx)*DataWidth +: DataWidth];
          core_d  = gnt_idx;
          state_d = POST;
        end
      end
      POST: begin
        if (bus.tohost_ack_i) begin
          rr_ptr_d = CoreW'((32'(core_q) + 1) % NrCores);
          if (data_q[0]) begin
            code_d  = data_q[DataWidth-1:1];
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DrainCycles - 1)) begin
          state_d = EXITED;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      core_q   <= '0;
      code_q   <= '0;
      exit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      core_q   <= core_d;
      code_q   <= code_d;
      exit_q   <= exit_d;
    end
  end

  assign bus.tohost_valid_o = (state_q == POST);
  assign bus.tohost_data_o  = data_q;
  assign bus.tohost_core_o  = core_q;
  assign exit_o             = exit_q;
  assign exit_code_o        = code_q;
  assign busy_o             = (state_q != IDLE);
endmodule
